// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants: datapath widths, default reset PC
// and the {pc, inst} fetch entry carried from IF to ID.
package pipeline_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Small synchronous FIFO with combinational head read, synchronous clear,
// and push-while-full permitted when a pop happens in the same cycle.
module ifq_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
        return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign dout    = mem[rd_ptr_reg];
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: sequential fetch, credit-limited imem requests,
// in-order response collection into a prefetch FIFO. Optional IFQ_PERF_EN adds perf counters.
module if_fetch_queue
    import pipeline_pkg::*;
#(
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
`endif
);

    localparam int FCW = $clog2(DEPTH + 1);
    localparam int OCW = $clog2(MAX_OUTST + 1);
    localparam int TCW = $clog2(MAX_OUTST + 1);
    localparam int SW  = FCW + 1;

    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [OCW-1:0]    outstanding_reg, outstanding_next;
    logic [OCW-1:0]    drop_cnt_reg, drop_cnt_next;

    logic [FCW-1:0]    fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    fetch_entry_t      fifo_din;
    fetch_entry_t      fifo_head;

    logic [ADDR_W-1:0] tag_dout;
    logic              tag_full;
    logic              tag_empty;
    logic [TCW-1:0]    tag_count;

    logic [SW-1:0]     credit;
    logic              req_fire;
    logic              rsp_take;
    logic              rsp_drop;

    // Responses arriving with nothing tracked (e.g. stale after reset) are ignored.
    assign rsp_take = imem_rsp_valid & (outstanding_reg != '0) & ~tag_empty;
    assign rsp_drop = rsp_take & (drop_cnt_reg != '0);

    // Entries already buffered plus those still coming back that will be kept.
    assign credit = SW'(fifo_count) + SW'(outstanding_reg) - SW'(drop_cnt_reg);

    assign imem_req_valid = reset & ~redirect_valid
                          & (outstanding_reg < OCW'(MAX_OUTST)) & ~tag_full
                          & (credit < SW'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign out_valid = ~fifo_empty & ~redirect_valid;
    assign fifo_pop  = out_valid & out_ready;
    assign fifo_push = rsp_take & ~rsp_drop & ~redirect_valid & (~fifo_full | fifo_pop);
    assign fifo_din  = '{pc: tag_dout, inst: imem_rsp_data};
    assign out_pc    = fifo_empty ? '0 : fifo_head.pc;
    assign out_inst  = fifo_empty ? '0 : fifo_head.inst;

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        outstanding_next = outstanding_reg + OCW'(req_fire) - OCW'(rsp_take);
        drop_cnt_next    = drop_cnt_reg - OCW'(rsp_drop);
        if (redirect_valid) begin
            fetch_pc_next = align_word(redirect_pc);
            // Everything still in flight after this cycle must be discarded.
            drop_cnt_next = outstanding_reg - OCW'(rsp_take);
        end else if (req_fire) begin
            fetch_pc_next = fetch_pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    ifq_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_prefetch_fifo (
        .clk   (clock),
        .rst_n (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .clear (redirect_valid),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Tags are never flushed: dropped responses still consume their tag in order.
    ifq_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_queue (
        .clk   (clock),
        .rst_n (reset),
        .push  (req_fire),
        .din   (fetch_pc_reg),
        .pop   (rsp_take),
        .clear (1'b0),
        .dout  (tag_dout),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

    logic unused_ok;
    assign unused_ok = &{1'b0, tag_count, redirect_pc[1:0]};

`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stall_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_fetched_reg <= '0;
            perf_stall_reg   <= '0;
        end else begin
            if (fifo_pop)               perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (out_valid && !out_ready) perf_stall_reg  <= perf_stall_reg + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stall   = perf_stall_reg;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a small in-order imem model.
// Perf-counter checks are active when IFQ_PERF_EN is defined.
module tb_if_fetch_queue;

    localparam int MAX_OUTST = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    if_fetch_queue dut (
        .clock          (clock),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
`ifdef IFQ_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    // imem model and bench bookkeeping
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          cyc;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          ready_rand = 0;
    logic [31:0] exp_pc;
    int          fires;
    int          reqs;
    int          stalls;
    int          first_out_cyc;
    bit          redir_now = 0;
    logic [31:0] redir_target;
    bit          watch_req;
    logic [31:0] watch_addr;
    int          watch_cyc;
    logic        pre_out_valid;
    logic        pre_rsp;
    logic [31:0] pre_out_pc;

    task automatic cycle();
        logic        req_f;
        logic        out_f;
        logic [31:0] req_a;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(pend_addr[0]);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        imem_req_ready = ready_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        #1;
        pre_out_valid = out_valid;
        pre_out_pc    = out_pc;
        pre_rsp       = imem_rsp_valid;
        if (redir_now) begin
            redirect_pc    = redir_target;
            redirect_valid = 1'b1;
            #1;
        end
        req_f = imem_req_valid && imem_req_ready;
        req_a = imem_req_addr;
        out_f = out_valid && out_ready;
        if (out_f) begin
            $display("OUT cyc=%0d pc=%h inst=%h", cyc, out_pc, out_inst);
            check_eq("out_pc", out_pc, exp_pc);
            check_eq("out_inst", out_inst, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            fires++;
            if (fires == 1) first_out_cyc = cyc;
        end
        if (out_valid && !out_ready) stalls++;
        if (req_f) reqs++;
        if (req_f && watch_req) begin
            check_eq("first_req_addr", req_a, watch_addr);
            watch_cyc = cyc;
            watch_req = 0;
        end
        if (redir_now) begin
            exp_pc     = {redir_target[31:2], 2'b00};
            watch_req  = 1;
            watch_addr = exp_pc;
        end
        @(posedge clock);
        if (imem_rsp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (req_f) begin
            pend_addr.push_back(req_a);
            pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
        check_eq("inflight_le_max", 32'(pend_addr.size() <= MAX_OUTST), 32'd1);
        cyc++;
        @(negedge clock);
        redirect_valid = 1'b0;
        redir_now      = 0;
    endtask

    task automatic hold_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        pend_addr.delete();
        pend_due.delete();
        @(negedge clock);
        @(negedge clock);
    endtask

    task automatic release_reset();
        reset         = 1'b1;
        cyc           = 0;
        exp_pc        = 32'h3000;
        fires         = 0;
        reqs          = 0;
        stalls        = 0;
        first_out_cyc = -1;
        watch_req     = 0;
        watch_cyc     = -1;
    endtask

    initial begin
        int f0;
        int guard;

        // Reset state
        hold_reset();
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_pc", out_pc, 32'h0);
        check_eq("rst_out_inst", out_inst, 32'h0);
        check_eq("rst_req_addr", imem_req_addr, 32'h3000);

        // Streaming, 1-cycle imem latency, no stalls
        release_reset();
        lat_min = 1; lat_max = 1; out_ready = 1'b1;
        repeat (12) cycle();
        check_eq("t1_first_out_cyc", 32'(first_out_cyc), 32'd2);
        check_eq("t1_fires", 32'(fires), 32'd10);

        // Decode stall fills the FIFO, then drains in order
        hold_reset();
        release_reset();
        out_ready = 1'b0;
        repeat (10) cycle();
        check_eq("t2_reqs_while_stalled", 32'(reqs), 32'd4);
        check_eq("t2_req_valid_full", 32'(imem_req_valid), 32'd0);
        check_eq("t2_out_valid", 32'(out_valid), 32'd1);
        check_eq("t2_head_pc", out_pc, 32'h3000);
        out_ready = 1'b1;
        repeat (10) cycle();
        check_eq("t2_drain_fires", 32'(fires), 32'd10);

        // Redirect with two requests in flight
        hold_reset();
        release_reset();
        lat_min = 3; lat_max = 3; out_ready = 1'b1;
        cycle();
        cycle();
        check_eq("t3_inflight_at_redirect", 32'(pend_addr.size()), 32'd2);
        redir_target = 32'h0000_3403;
        redir_now    = 1;
        cycle();
        repeat (9) cycle();
        check_eq("t3_first_req_cyc", 32'(watch_cyc), 32'd4);
        check_eq("t3_fires", 32'(fires), 32'd2);

        // Redirect coinciding with a response and a would-be output handshake
        hold_reset();
        release_reset();
        lat_min = 2; lat_max = 2; out_ready = 1'b0;
        repeat (5) cycle();
        check_eq("t4_inflight_before", 32'(pend_addr.size()), 32'd2);
        out_ready    = 1'b1;
        redir_target = 32'h0000_5008;
        redir_now    = 1;
        f0 = fires;
        cycle();
        check_eq("t4_rsp_in_redirect_cyc", 32'(pre_rsp), 32'd1);
        check_eq("t4_head_valid_before", 32'(pre_out_valid), 32'd1);
        check_eq("t4_head_pc_before", pre_out_pc, 32'h3000);
        check_eq("t4_no_xfer_on_redirect", 32'(fires - f0), 32'd0);
        cycle();
        check_eq("t4_empty_after_redirect", 32'(pre_out_valid), 32'd0);
        check_eq("t4_first_req_cyc", 32'(watch_cyc), 32'd6);
        repeat (6) cycle();
        check_eq("t4_fires_after", 32'(fires - f0), 32'd3);

        // Random imem backpressure and latency
        hold_reset();
        release_reset();
        lat_min = 1; lat_max = 3; ready_rand = 1;
        repeat (80) begin
            out_ready = 1'($urandom_range(1, 0));
            cycle();
        end
        ready_rand = 0;
        out_ready  = 1'b1;
        repeat (10) cycle();
        check_eq("t5_progress", 32'(fires >= 10), 32'd1);

        // Delivery/stall accounting, then asynchronous reset mid-run
        hold_reset();
        release_reset();
        lat_min = 1; lat_max = 1; out_ready = 1'b0;
        guard = 0;
        while (stalls < 7 && guard < 50) begin
            cycle();
            guard++;
        end
        check_eq("t6_stalls", 32'(stalls), 32'd7);
        out_ready = 1'b1;
        guard = 0;
        while (fires < 20 && guard < 100) begin
            cycle();
            guard++;
        end
        check_eq("t6_fires", 32'(fires), 32'd20);
        out_ready = 1'b0;
        #1;
`ifdef IFQ_PERF_EN
        check_eq("t6_perf_fetched", perf_fetched, 32'd20);
        check_eq("t6_perf_stall", perf_stall, 32'd7);
`endif
        check_eq("t6_valid_before_reset", 32'(out_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("t6_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("t6_rst_out_pc", out_pc, 32'h0);
        check_eq("t6_rst_out_inst", out_inst, 32'h0);
`ifdef IFQ_PERF_EN
        check_eq("t6_rst_perf_fetched", perf_fetched, 32'd0);
        check_eq("t6_rst_perf_stall", perf_stall, 32'd0);
`endif
        hold_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
